seq_match_window_counter: RTL

//  Downstream consumer of the serial sequence detectors' registered match pulse (y).

---
 rtl/seq_match_window_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_match_window_counter.sv
// Counts match pulses over back-to-back programmable windows, publishes each
// window's final count and latches an alarm when a window reaches threshold.
module seq_match_window_counter #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             match,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] last_count,
    output logic             window_done,
    output logic             alarm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_n;
    logic [WIN_W-1:0] timer, timer_n;
    logic [WIN_W-1:0] len, len_n;
    logic [CNT_W-1:0] count_n, last_count_n;
    logic             window_done_n, alarm_n;

    logic [CNT_W-1:0] c_sat;
    logic [WIN_W-1:0] start_len;
    logic             last_cycle;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= {WIN_W{1'b0}};
            len         <= WIN_W'(1);
            count       <= {CNT_W{1'b0}};
            last_count  <= {CNT_W{1'b0}};
            window_done <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            len         <= len_n;
            count       <= count_n;
            last_count  <= last_count_n;
            window_done <= window_done_n;
            alarm       <= alarm_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        // c_sat includes a match landing on the window's last cycle
        c_sat         = (match && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
        start_len     = (window_len == {WIN_W{1'b0}}) ? WIN_W'(1) : window_len;
        last_cycle    = (timer == len - WIN_W'(1));
        state_n       = state;
        timer_n       = timer;
        len_n         = len;
        count_n       = count;
        last_count_n  = last_count;
        window_done_n = 1'b0;
        alarm_n       = alarm;

        if (clear) begin
            state_n      = IDLE;
            timer_n      = {WIN_W{1'b0}};
            count_n      = {CNT_W{1'b0}};
            last_count_n = {CNT_W{1'b0}};
            alarm_n      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer_n = {WIN_W{1'b0}};
                    count_n = {CNT_W{1'b0}};
                    if (enable) begin
                        state_n = RUN;
                        len_n   = start_len;
                    end else begin
                        state_n = IDLE;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_n = IDLE;
                        timer_n = {WIN_W{1'b0}};
                        count_n = {CNT_W{1'b0}};
                    end else if (last_cycle) begin
                        last_count_n  = c_sat;
                        window_done_n = 1'b1;
                        if ((threshold != {CNT_W{1'b0}}) && (c_sat >= threshold)) begin
                            state_n = HOLD;
                            count_n = c_sat;
                            alarm_n = 1'b1;
                        end else begin
                            timer_n = {WIN_W{1'b0}};
                            count_n = {CNT_W{1'b0}};
                            len_n   = start_len;
                        end
                    end else begin
                        timer_n = timer + WIN_W'(1);
                        count_n = c_sat;
                    end
                end
                HOLD: begin
                    state_n = HOLD;
                end
                default: begin
                    state_n = IDLE;
                    timer_n = {WIN_W{1'b0}};
                    count_n = {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
